// File: rtl/uart_imem_loader.sv
// UART 8N1 boot loader: receives a 16-bit word count followed by
// little-endian instruction words and writes them into instruction memory.
module uart_imem_loader #(
    parameter int CLK_DIV    = 868,
    parameter int IMEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        start,
    output logic        imem_we,
    output logic [13:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_q;
    logic [1:0]    rx_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          byte_valid;
    logic          frame_err;

    logic [2:0]    state;
    logic [15:0]   n_len;
    logic [1:0]    byte_cnt;
    logic [15:0]   len_next;
    logic          len_ok;
    logic          last_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_q       <= 1'b1;
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_q       <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_q && !rx_s2) begin
                        rx_state <= RX_START;
                        clk_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        bit_cnt <= 3'd0;
                        // a start bit gone high by mid-bit was only a glitch
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt    <= '0;
                        rx_state   <= RX_IDLE;
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign len_next  = {shreg, n_len[7:0]};
    assign len_ok    = (len_next != 16'd0) &&
                       ({16'd0, len_next} <= 32'(IMEM_WORDS));
    assign last_word = ({2'b00, imem_addr} + 16'd1) == n_len;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            n_len      <= 16'd0;
            byte_cnt   <= 2'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 14'd0;
            imem_wdata <= 32'd0;
            cpu_rst    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            cpu_rst <= (state == S_IDLE || state == S_DONE) && !start;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_LEN_LO;
                        imem_addr <= 14'd0;
                        byte_cnt  <= 2'd0;
                    end
                end
                S_LEN_LO: begin
                    if (frame_err) begin
                        state <= S_ERR;
                    end else if (byte_valid) begin
                        n_len[7:0] <= shreg;
                        state      <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (frame_err) begin
                        state <= S_ERR;
                    end else if (byte_valid) begin
                        n_len[15:8] <= shreg;
                        state       <= len_ok ? S_DATA : S_ERR;
                    end
                end
                S_DATA: begin
                    if (frame_err) begin
                        state <= S_ERR;
                    end else if (imem_we) begin
                        imem_addr <= imem_addr + 14'd1;
                        if (last_word) state <= S_DONE;
                    end else if (byte_valid) begin
                        imem_wdata[{byte_cnt, 3'b000} +: 8] <= shreg;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) imem_we <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                  (state == S_DATA);
    assign done = (state == S_DONE);
    assign err  = (state == S_ERR);

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 868, giving clocks per UART bit (100 MHz / 115200).
REQ-002 The block SHALL have parameter IMEM_WORDS, default 16384, giving the instruction-memory depth in 32-bit words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous UART serial line, 8N1, idle high.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle pulse that arms a new program load.
REQ-007 The block SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-008 The block SHALL have port imem_addr, output, 14 bits: word address of the write.
REQ-009 The block SHALL have port imem_wdata, output, 32 bits: instruction word to write.
REQ-010 The block SHALL have port cpu_rst, output, 1 bit: active-low reset driven to the CPU core; low holds the core.
REQ-011 The block SHALL have ports busy, done and err, outputs, 1 bit each: load in progress, load finished successfully, load aborted.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The receiver SHALL detect a start bit on a synchronized 1->0 transition while idle, re-sample at CLK_DIV/2 clocks, and abandon the frame without emitting a byte if rx is high at that sample.
REQ-014 The receiver SHALL sample data bits LSB first every CLK_DIV clocks, then sample the stop bit; a low stop bit SHALL be a framing error.
REQ-015 The receiver SHALL raise a one-cycle byte_valid on the clock after the stop-bit sample; the next start bit SHALL be accepted from the following clock.
REQ-016 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA, DONE and ERR.
REQ-017 IDLE, DONE or ERR plus start SHALL move to LEN_LO, clear the word address and byte counter, and clear done and err.
REQ-018 start SHALL be ignored in LEN_LO, LEN_HI and DATA.
REQ-019 LEN_LO SHALL latch the received byte as N[7:0], then go to LEN_HI.
REQ-020 LEN_HI SHALL latch the received byte as N[15:8] and go to DATA if 1 <= N <= IMEM_WORDS, else go to ERR.
REQ-021 DATA SHALL assemble 4 bytes little-endian, with the first byte going to imem_wdata[7:0].
REQ-022 On the 4th byte_valid, DATA SHALL pulse imem_we for exactly one cycle on the next clock, with imem_addr and imem_wdata stable in that cycle.
REQ-023 imem_addr SHALL increment by 1 after each write.
REQ-024 After the N-th write, the FSM SHALL go to DONE.
REQ-025 A framing error in LEN_LO, LEN_HI or DATA SHALL go to ERR immediately, with no further imem_we.
REQ-026 In IDLE, framing errors SHALL be ignored.
REQ-027 busy SHALL be 1 in LEN_LO, LEN_HI and DATA, and 0 otherwise.
REQ-028 done SHALL be 1 only in DONE.
REQ-029 err SHALL be 1 only in ERR.
REQ-030 cpu_rst SHALL be 0 in LEN_LO, LEN_HI, DATA and ERR, and 1 in IDLE and DONE.
REQ-031 cpu_rst SHALL be registered and SHALL rise on the first clock after entering DONE.
REQ-032 Bytes received in IDLE, DONE or ERR SHALL be discarded.
REQ-033 A partial word pending at ERR SHALL never be written.

Reset
REQ-034 While rst=0 at a clock edge, the FSM SHALL be in IDLE and the receiver idle.
REQ-035 Under reset: imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, byte counter=0.
REQ-036 Under reset, cpu_rst SHALL be 0 and SHALL become 1 on the first clock after rst returns high.
REQ-037 Reset asserted mid-load SHALL abort the load with no further imem_we.

Verification
REQ-038 Start pulse, then bytes 02 00 13 05 10 00 93 05 20 00 -> imem_we at addr 0 with 0x00100513, at addr 1 with 0x00200593, then done=1, cpu_rst=1.
REQ-039 Length bytes 00 00 -> err=1, cpu_rst=0, zero imem_we pulses; a following start plus valid stream -> loads correctly.
REQ-040 N=1, stop bit forced low on the 3rd data byte -> err=1 on the next clock, no imem_we.
REQ-041 A 0.25-bit low glitch on rx while idle -> no byte_valid and no state change.
REQ-042 rst=0 asserted after 5 of 8 data bytes -> all outputs at reset values, imem_we stays 0.
REQ-043 start pulses during DATA -> ignored, and imem_addr sequence unchanged.
